// File: rtl/uart_beacon_pkg.sv
// Shared types and ASCII helpers for the UART beacon counter.
package uart_beacon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_HEX,
    ST_CR,
    ST_LF
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;

  function automatic logic [7:0] nibble_to_ascii(
    input logic [3:0] n
  );
    if (n < 4'd10)
      return ASCII_0 + {4'h0, n};
    else
      return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Free-running modulo-PERIOD counter with a one-cycle tick
// on the enabled wrap edge.
module period_tick_gen #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned PERIOD      = 1000000000
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_tick
);

  localparam logic [COUNT_WIDTH-1:0] LAST =
    COUNT_WIDTH'(PERIOD - 1);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  assign o_tick  = i_enable && (count_q == LAST);
  assign o_count = count_q;

  always_comb begin
    count_d = count_q;
    if (i_enable)
      count_d = (count_q == LAST) ? '0
              : count_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (i_reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/uart_beacon_counter.sv
// Period counter that streams "<PREFIX><hex seq>[CR LF]"
// to a UART TX over valid/ready on every period wrap.
module uart_beacon_counter
  import uart_beacon_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned PERIOD      = 1000000000,
  parameter int unsigned SEQ_WIDTH   = 8,
  parameter logic [7:0]  PREFIX      = 8'h41,
  parameter bit          NEWLINE     = 1'b1
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_clear_overrun,
  input  logic                   i_tx_ready,
  output logic                   o_tx_valid,
  output logic [7:0]             o_tx_data,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic [SEQ_WIDTH-1:0]   o_seq,
  output logic                   o_busy,
  output logic                   o_overrun
);

  localparam int unsigned NDIG = SEQ_WIDTH / 4;
  localparam int unsigned IW =
    (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_DIG = IW'(NDIG - 1);

  logic                 tick;
  logic                 xfer;
  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [SEQ_WIDTH-1:0] snap_q, snap_d;
  logic [SEQ_WIDTH-1:0] seq_q;
  logic                 ovr_q;
  logic                 valid_q, valid_d;
  logic [7:0]           data_q, data_d;

  period_tick_gen #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .PERIOD      (PERIOD)
  ) u_tick (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_count  (o_count),
    .o_tick   (tick)
  );

  assign xfer = valid_q && i_tx_ready;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      seq_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (tick)
        seq_q <= seq_q + SEQ_WIDTH'(1);
      // a drop wins over a clear in the same cycle
      if (tick && state_q != ST_IDLE)
        ovr_q <= 1'b1;
      else if (i_clear_overrun)
        ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    unique case (state_q)
      ST_IDLE: if (tick) begin
        state_d = ST_PREFIX;
        snap_d  = seq_q;
      end
      ST_PREFIX: if (xfer) begin
        state_d = ST_HEX;
        idx_d   = LAST_DIG;
      end
      ST_HEX: if (xfer) begin
        if (idx_q == '0)
          state_d = NEWLINE ? ST_CR : ST_IDLE;
        else
          idx_d = idx_q - IW'(1);
      end
      ST_CR: if (xfer) state_d = ST_LF;
      ST_LF: if (xfer) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs are registered from the next state, so they
  // hold still whenever the FSM is stalled
  always_comb begin
    valid_d = (state_d != ST_IDLE);
    data_d  = '0;
    case (state_d)
      ST_PREFIX: data_d = PREFIX;
      ST_HEX:    data_d = nibble_to_ascii(
                   4'(snap_q >> {idx_d, 2'b00}));
      ST_CR:     data_d = ASCII_CR;
      ST_LF:     data_d = ASCII_LF;
      default:   data_d = '0;
    endcase
  end

  assign o_tx_valid = valid_q;
  assign o_tx_data  = data_q;
  assign o_seq      = seq_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_uart_beacon_counter.sv
// Bench for uart_beacon_counter: message-queue model plus
// directed scenarios on NEWLINE=1 and NEWLINE=0 instances.
module tb_uart_beacon_counter;

  localparam int PER = 8;

  logic clk = 1'b0;
  logic rst, en, clr, rdy;

  logic        v0, v1, busy0, busy1, ov0, ov1;
  logic [7:0]  d0, d1, seq0, seq1;
  logic [31:0] cnt0, cnt1;

  int n_tot  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  logic [7:0] log0[$];
  logic [7:0] log1[$];

  always #5 clk = ~clk;

  uart_beacon_counter #(
    .COUNT_WIDTH (32), .PERIOD (PER), .SEQ_WIDTH (8),
    .PREFIX (8'h41), .NEWLINE (1'b1)
  ) dut0 (
    .clk (clk), .i_reset (rst), .i_enable (en),
    .i_clear_overrun (clr), .i_tx_ready (rdy),
    .o_tx_valid (v0), .o_tx_data (d0), .o_count (cnt0),
    .o_seq (seq0), .o_busy (busy0), .o_overrun (ov0)
  );

  uart_beacon_counter #(
    .COUNT_WIDTH (32), .PERIOD (PER), .SEQ_WIDTH (8),
    .PREFIX (8'h41), .NEWLINE (1'b0)
  ) dut1 (
    .clk (clk), .i_reset (rst), .i_enable (en),
    .i_clear_overrun (clr), .i_tx_ready (rdy),
    .o_tx_valid (v1), .o_tx_data (d1), .o_count (cnt1),
    .o_seq (seq1), .o_busy (busy1), .o_overrun (ov1)
  );

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  // size in the top byte, bytes packed in arrival order
  function automatic logic [63:0] pk(input logic [7:0] q[$]);
    logic [63:0] v;
    v = {8'(q.size()), 56'h0};
    foreach (q[i]) v[55:0] = {v[47:0], q[i]};
    return v;
  endfunction

  // model: each instance owns a queue of bytes still to send
  string      hx = "0123456789ABCDEF";
  int         m_cnt = 0;
  logic [7:0] m_seq = '0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_ov0 = 0, m_ov1 = 0;
  bit         m_tick, m_b0, m_b1;
  logic [7:0] h_hi, h_lo;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_seq = '0;
      q0.delete(); q1.delete();
      m_ov0 = 0; m_ov1 = 0;
    end else begin
      m_b0 = q0.size() != 0;
      m_b1 = q1.size() != 0;
      m_tick = en && (m_cnt == PER - 1);
      if (en) m_cnt = m_tick ? 0 : m_cnt + 1;
      if (m_b0 && rdy) void'(q0.pop_front());
      if (m_b1 && rdy) void'(q1.pop_front());
      if (m_tick) begin
        h_hi = hx[int'(m_seq[7:4])];
        h_lo = hx[int'(m_seq[3:0])];
        if (!m_b0) begin
          q0.push_back(8'h41); q0.push_back(h_hi);
          q0.push_back(h_lo);
          q0.push_back(8'h0D); q0.push_back(8'h0A);
        end
        if (!m_b1) begin
          q1.push_back(8'h41); q1.push_back(h_hi);
          q1.push_back(h_lo);
        end
        m_seq = m_seq + 8'd1;
      end
      if (m_tick && m_b0) m_ov0 = 1; else if (clr) m_ov0 = 0;
      if (m_tick && m_b1) m_ov1 = 1; else if (clr) m_ov1 = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && v0 === 1'b1 && rdy) log0.push_back(d0);
    if (!rst && v1 === 1'b1 && rdy) log1.push_back(d1);
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("count", cnt0, 64'(m_cnt));
      chk("seq", seq0, m_seq);
      chk("valid0", v0, q0.size() != 0);
      chk("busy0", busy0, q0.size() != 0);
      chk("ovr0", ov0, m_ov0);
      if (q0.size() != 0) chk("data0", d0, q0[0]);
      chk("valid1", v1, q1.size() != 0);
      chk("busy1", busy1, q1.size() != 0);
      chk("ovr1", ov1, m_ov1);
      if (q1.size() != 0) chk("data1", d1, q1[0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_prefix();
    int n = 0;
    while (!(v0 === 1'b1 && d0 == 8'h41) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("wait_prefix", n < 300, 1);
  endtask

  task automatic wait_seq_ff();
    int n = 0;
    while (seq0 !== 8'hFF && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("wait_seq_ff", n < 3000, 1);
  endtask

  task automatic wait_count5();
    int n = 0;
    while (cnt0 !== 32'd5 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("wait_count5", n < 50, 1);
  endtask

  initial begin
    rst = 1; en = 0; rdy = 1; clr = 0;
    cyc(2);
    chk_en = 1;
    chk("rst_count", cnt0, 0);
    chk("rst_seq", seq0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_ovr", ov0, 0);
    chk("rst_busy", busy0, 0);

    // first message, ready held high
    rst = 0; en = 1;
    log0.delete(); log1.delete();
    cyc(13);
    chk("t1_msg", pk(log0), 64'h05_0000_41_30_30_0D_0A);
    chk("t1_msg_nl0", pk(log1), 64'h03_00000000_41_30_30);
    chk("t1_seq", seq0, 8'h01);
    chk("t1_busy", busy0, 0);
    chk("t1_ovr", ov0, 0);

    // stall on the first hex digit
    log0.delete();
    wait_prefix();
    cyc(1);
    rdy = 0;
    repeat (3) begin
      cyc(1);
      chk("t2_hold_data", d0, 8'h30);
      chk("t2_hold_valid", v0, 1);
    end
    rdy = 1;
    cyc(4);
    chk("t2_msg", pk(log0), 64'h05_0000_41_30_31_0D_0A);
    chk("t2_tick_on_last", ov0, 1);
    chk("t2_busy", busy0, 0);
    chk("t2_seq", seq0, 8'h03);

    // long stall drops a tick
    clr = 1; cyc(1); clr = 0;
    chk("t3_clr", ov0, 0);
    log0.delete();
    rdy = 0;
    cyc(20);
    chk("t3_ovr", ov0, 1);
    chk("t3_seq", seq0, 8'h05);
    chk("t3_stall_data", d0, 8'h41);
    rdy = 1;
    cyc(5);
    chk("t3_msg", pk(log0), 64'h05_0000_41_30_33_0D_0A);
    clr = 1; cyc(1); clr = 0;
    chk("t3_clr2", ov0, 0);
    log0.delete();
    wait_prefix();
    cyc(5);
    chk("t3_next", pk(log0), 64'h05_0000_41_30_36_0D_0A);

    // sequence wrap
    rst = 1; cyc(1); rst = 0;
    wait_seq_ff();
    cyc(6);
    log0.delete();
    wait_prefix();
    chk("t4_wrap_seq", seq0, 8'h00);
    cyc(5);
    chk("t4_ff", pk(log0), 64'h05_0000_41_46_46_0D_0A);
    log0.delete();
    wait_prefix();
    cyc(5);
    chk("t4_00", pk(log0), 64'h05_0000_41_30_30_0D_0A);

    // reset mid-message
    wait_prefix();
    cyc(2);
    rst = 1; cyc(1); rst = 0;
    log0.delete();
    chk("t5_valid", v0, 0);
    chk("t5_count", cnt0, 0);
    chk("t5_seq", seq0, 0);
    wait_prefix();
    cyc(5);
    chk("t5_msg", pk(log0), 64'h05_0000_41_30_30_0D_0A);

    // enable gating and the NEWLINE=0 ending
    wait_count5();
    en = 0;
    cyc(10);
    chk("t6_hold", cnt0, 5);
    log1.delete();
    en = 1;
    cyc(3);
    chk("t6_wrap", cnt0, 0);
    chk("t6_valid", v0, 1);
    chk("t6_prefix", d0, 8'h41);
    cyc(3);
    chk("t6_nl0_msg", pk(log1), 64'h03_00000000_41_30_31);
    chk("t6_nl0_idle", busy1, 0);
    chk("t6_seq", seq0, 8'h02);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
